// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetches 32-bit words from instruction memory into a small circular
// queue and presents the head entry to decode under a valid/ready handshake.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   input  logic        redirectValid,
   input  logic [31:0] redirectPc,
   output logic        instrValid,
   input  logic        instrReady,
   output logic [31:0] instr,
   output logic [31:0] instrPc,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7
);

   // state    | meaning
   // ST_FETCH | normal fetching; request while the queue has room
   // ST_FLUSH | redirect arrived with a request in flight; wait for its ack, drop the data

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);
   localparam logic [31:0]      NOP     = 32'h0000_0013;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [31:0]       target_q, target_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [31:0]       buf_instr_q [DEPTH];
   logic [31:0]       buf_instr_d [DEPTH];
   logic [31:0]       buf_pc_q    [DEPTH];
   logic [31:0]       buf_pc_d    [DEPTH];

   logic              transfer;
   logic              push;
   logic              pop;
   logic              not_empty;
   logic [31:0]       redirect_pc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   assign not_empty   = (count_q != '0);
   assign redirect_pc = redirectPc & 32'hFFFF_FFFC;
   assign transfer    = req_q && imemAck;
   assign pop         = instrValid && instrReady;
   // A redirect discards whatever would have been pushed on the same edge.
   assign push        = (state_q == ST_FETCH) && transfer && !redirectValid;

   assign imemReq    = req_q;
   assign imemAddr   = fetch_pc_q;
   assign instrValid = not_empty && !redirectValid;
   assign instr      = not_empty ? buf_instr_q[rd_ptr_q] : NOP;
   assign instrPc    = not_empty ? buf_pc_q[rd_ptr_q] : 32'h0000_0000;
   assign opcode     = instr[6:0];
   assign funct3     = instr[14:12];
   assign funct7     = instr[31:25];

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      target_d    = target_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;

      if (redirectValid) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         if (state_q == ST_FETCH) begin
            if (!req_q || imemAck) begin
               fetch_pc_d = redirect_pc;
            end else begin
               state_d  = ST_FLUSH;
               target_d = redirect_pc;
            end
         end else if (imemAck) begin
            // The in-flight request completes here, so the newest target can be used directly.
            state_d    = ST_FETCH;
            fetch_pc_d = redirect_pc;
         end else begin
            target_d = redirect_pc;
         end
      end else begin
         if (state_q == ST_FLUSH) begin
            if (imemAck) begin
               state_d    = ST_FETCH;
               fetch_pc_d = target_q;
            end
         end else if (transfer) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (push) begin
            buf_instr_d[wr_ptr_q] = imemData;
            buf_pc_d[wr_ptr_q]    = fetch_pc_q;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end

      // Request is held until acked: count can only fall while a request is pending.
      req_d = (state_d == ST_FETCH) ? (count_d < DEPTH_C) : 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FETCH;
         req_q       <= 1'b0;
         fetch_pc_q  <= RESET_PC;
         target_q    <= RESET_PC;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         buf_instr_q <= '{default: '0};
         buf_pc_q    <= '{default: '0};
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         fetch_pc_q  <= fetch_pc_d;
         target_q    <= target_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic, checked by a
// scoreboard holding the expected decode stream (sequential PCs restarting at each redirect).
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck = 1'b0;
   logic [31:0] imemData;
   logic        redirectValid = 1'b0;
   logic [31:0] redirectPc = 32'h0;
   logic        instrValid;
   logic        instrReady = 1'b0;
   logic [31:0] instr;
   logic [31:0] instrPc;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;

   instruction_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imemReq       (imemReq),
      .imemAddr      (imemAddr),
      .imemAck       (imemAck),
      .imemData      (imemData),
      .redirectValid (redirectValid),
      .redirectPc    (redirectPc),
      .instrValid    (instrValid),
      .instrReady    (instrReady),
      .instr         (instr),
      .instrPc       (instrPc),
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7        (funct7)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_pop = 0;
   bit          const_data = 1'b0;
   logic [63:0] exp_q [$];
   logic [31:0] exp_next = RESET_PC;

   // Memory image: either a fixed ADDI word or a per-address hash.
   function automatic logic [31:0] word_at(input bit cd, input logic [31:0] a);
      if (cd) return 32'h00A0_0093;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
   endfunction

   always_comb imemData = word_at(const_data, imemAddr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void sb_fill();
      while (exp_q.size() < 4) begin
         exp_q.push_back({exp_next, word_at(const_data, exp_next)});
         exp_next += 32'd4;
      end
   endfunction

   function automatic void sb_restart(input logic [31:0] pc);
      exp_q.delete();
      exp_next = pc;
      sb_fill();
   endfunction

   // Monitor: protocol invariants every cycle, scoreboard compare on every decode handshake.
   logic        prev_ok = 1'b0;
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [31:0] prev_addr = 32'h0;

   always @(negedge clk) begin : monitor
      logic [63:0] e;
      if (!rst_n) begin
         prev_ok = 1'b0;
      end else begin
         if (prev_ok && prev_req && !prev_ack) begin
            chk("req_hold", 32'(imemReq), 32'd1);
            chk("addr_hold", imemAddr, prev_addr);
         end
         chk("addr_align", 32'(imemAddr[1:0]), 32'd0);
         if (redirectValid) begin
            chk("valid_masked", 32'(instrValid), 32'd0);
         end else if (!instrValid) begin
            chk("empty_instr", instr, NOP);
            chk("empty_pc", instrPc, 32'd0);
         end
         if (instrValid && instrReady) begin
            sb_fill();
            e = exp_q.pop_front();
            chk("sb_pc", instrPc, e[63:32]);
            chk("sb_instr", instr, e[31:0]);
            chk("sb_fields", {15'd0, funct7, funct3, opcode}, {15'd0, e[31:25], e[14:12], e[6:0]});
            n_pop++;
         end
         prev_ok   = 1'b1;
         prev_req  = imemReq;
         prev_ack  = imemAck;
         prev_addr = imemAddr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"}, 32'(imemReq), 32'd0);
      chk({tag, "_addr"}, imemAddr, RESET_PC);
      chk({tag, "_valid"}, 32'(instrValid), 32'd0);
      chk({tag, "_instr"}, instr, NOP);
      chk({tag, "_pc"}, instrPc, 32'd0);
   endtask

   task automatic do_reset(input bit cd);
      rst_n         = 1'b0;
      imemAck       = 1'b0;
      instrReady    = 1'b0;
      redirectValid = 1'b0;
      redirectPc    = 32'h0;
      const_data    = cd;
      sb_restart(RESET_PC);
      #1;
      check_reset_outputs("rst");
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic reach(input logic [31:0] a);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         smp();
         if (imemReq && imemAddr == a) hit = 1'b1;
         else tick();
      end
      chk("reach_addr", 32'(hit), 32'd1);
   endtask

   initial begin
      #2;

      // Zero-wait memory, decode always ready: one fetch per cycle, valid one cycle later.
      do_reset(1'b1);
      imemAck    = 1'b1;
      instrReady = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         smp();
         chk("t1_addr", imemAddr, 32'(4 * k));
         chk("t1_req", 32'(imemReq), 32'd1);
         chk("t1_valid", 32'(instrValid), 32'(k >= 1));
         if (k >= 1) begin
            chk("t1_pc", instrPc, 32'(4 * (k - 1)));
            chk("t1_opcode", 32'(opcode), 32'h13);
            chk("t1_funct3", 32'(funct3), 32'd0);
         end
         tick();
      end

      // Decode stalled: queue fills to two entries and requests stop.
      do_reset(1'b0);
      imemAck    = 1'b1;
      instrReady = 1'b0;
      repeat (5) tick();
      smp();
      chk("t2_req", 32'(imemReq), 32'd0);
      chk("t2_valid", 32'(instrValid), 32'd1);
      chk("t2_pc", instrPc, 32'd0);
      tick();
      instrReady = 1'b1;
      repeat (10) tick();

      // Memory acks three cycles late.
      do_reset(1'b0);
      imemAck    = 1'b1;
      instrReady = 1'b1;
      reach(32'h4);
      tick();
      imemAck = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t3_req", 32'(imemReq), 32'd1);
         chk("t3_addr", imemAddr, 32'h8);
         tick();
      end
      imemAck = 1'b1;
      smp();
      tick();
      smp();
      chk("t3_next_addr", imemAddr, 32'hC);
      tick();
      repeat (4) tick();

      // Redirect while a request is in flight: flush and refetch from the aligned target.
      do_reset(1'b0);
      imemAck    = 1'b1;
      instrReady = 1'b1;
      reach(32'h4);
      tick();
      imemAck = 1'b0;
      smp();
      chk("t4_pending_addr", imemAddr, 32'h8);
      tick();
      redirectValid = 1'b1;
      redirectPc    = 32'h103;
      sb_restart(32'h100);
      smp();
      chk("t4_valid_redirect", 32'(instrValid), 32'd0);
      tick();
      redirectValid = 1'b0;
      smp();
      chk("t4_flush_req", 32'(imemReq), 32'd1);
      chk("t4_flush_addr", imemAddr, 32'h8);
      tick();
      smp();
      chk("t4_flush_addr2", imemAddr, 32'h8);
      tick();
      imemAck = 1'b1;
      smp();
      tick();
      smp();
      chk("t4_target_req", 32'(imemReq), 32'd1);
      chk("t4_target_addr", imemAddr, 32'h100);
      tick();
      repeat (6) tick();

      // Redirect, pop and ack on the same edge.
      do_reset(1'b0);
      imemAck    = 1'b1;
      instrReady = 1'b1;
      reach(32'h8);
      chk("t5_valid_before", 32'(instrValid), 32'd1);
      tick();
      redirectValid = 1'b1;
      redirectPc    = 32'h200;
      sb_restart(32'h200);
      smp();
      chk("t5_valid_redirect", 32'(instrValid), 32'd0);
      tick();
      redirectValid = 1'b0;
      smp();
      chk("t5_valid_after", 32'(instrValid), 32'd0);
      chk("t5_req", 32'(imemReq), 32'd1);
      chk("t5_addr", imemAddr, 32'h200);
      tick();
      smp();
      chk("t5_first_valid", 32'(instrValid), 32'd1);
      chk("t5_first_pc", instrPc, 32'h200);
      tick();

      // Redirect to the top word, wrap to zero, then asynchronous reset mid-request.
      do_reset(1'b0);
      imemAck    = 1'b1;
      instrReady = 1'b1;
      tick();
      redirectValid = 1'b1;
      redirectPc    = 32'hFFFF_FFFF;
      sb_restart(32'hFFFF_FFFC);
      smp();
      tick();
      redirectValid = 1'b0;
      smp();
      chk("t6_top_addr", imemAddr, 32'hFFFF_FFFC);
      tick();
      smp();
      chk("t6_wrap_addr", imemAddr, 32'h0);
      tick();
      imemAck = 1'b0;
      smp();
      chk("t6_pending_req", 32'(imemReq), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6_async");
      const_data = 1'b0;
      sb_restart(RESET_PC);
      tick();
      tick();
      rst_n = 1'b1;
      smp();
      chk("t6_no_req_yet", 32'(imemReq), 32'd0);
      tick();
      smp();
      chk("t6_restart_req", 32'(imemReq), 32'd1);
      chk("t6_restart_addr", imemAddr, RESET_PC);
      tick();
      imemAck = 1'b1;
      repeat (8) tick();

      // Randomized traffic: ack/ready jitter and occasional redirects.
      do_reset(1'b0);
      for (int c = 0; c < 3000; c++) begin
         tick();
         imemAck    = ($urandom_range(0, 99) < 60);
         instrReady = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 99) < 3) begin
            redirectValid = 1'b1;
            redirectPc    = $urandom;
            sb_restart(redirectPc & 32'hFFFF_FFFC);
         end else begin
            redirectValid = 1'b0;
         end
      end
      tick();
      redirectValid = 1'b0;
      imemAck       = 1'b1;
      instrReady    = 1'b1;
      repeat (20) tick();

      chk("progress", 32'(n_pop > 200), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
      $fatal(1);
   end

endmodule
